serial_alu_ctrl: RTL



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_bit_slice.sv | 52 +++++
 rtl/serial_alu_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the bit-serial ALU sequencer:
//   - ALU op codes (alu_ctrl[1:0])
//   - alu_ctrl field positions and a packed view of the control nibble
//   - 2-bit FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    // Bit positions inside alu_ctrl
    localparam int CTRL_AINV = 3;
    localparam int CTRL_BINV = 2;
    localparam int CTRL_OPHI = 1;
    localparam int CTRL_OPLO = 0;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
    } alu_ctrl_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/alu_bit_slice.sv
// ---------------------------------------------------------------------------
// alu_bit_slice
//   One combinational MIPS-style ALU bit.
//   Inputs : i_a, i_b (raw operand bits), i_less (value returned for SLT),
//            i_a_invert, i_b_invert, i_cin, i_op[1:0]
//   Outputs: o_res  (selected result bit)
//            o_set  (less-than flag, valid when this is the MSB slice)
//            o_ovf  (signed overflow, ADD only, valid at the MSB slice)
//            o_cout (carry out)
// ---------------------------------------------------------------------------
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_less,
    input  logic       i_a_invert,
    input  logic       i_b_invert,
    input  logic       i_cin,
    input  logic [1:0] i_op,
    output logic       o_res,
    output logic       o_set,
    output logic       o_ovf,
    output logic       o_cout
);

    logic w_ai, w_bi, w_sum;

    assign w_ai   = i_a ^ i_a_invert;
    assign w_bi   = i_b ^ i_b_invert;
    assign w_sum  = w_ai ^ w_bi ^ i_cin;
    assign o_cout = (w_ai & w_bi) | (w_ai & i_cin) | (w_bi & i_cin);

    // Differing signs decide SLT directly from the raw MSBs; this keeps the
    // answer right even when a-b overflows. Equal signs cannot overflow, so
    // the sign of the difference is trustworthy there.
    assign o_set = (i_a & ~i_b) ? 1'b1 :
                   (~i_a & i_b) ? 1'b0 : w_sum;

    assign o_ovf = (i_op == ALU_ADD) & (i_cin ^ o_cout);

    always_comb begin
        o_res = 1'b0;
        case (i_op)
            ALU_AND: o_res = w_ai & w_bi;
            ALU_OR:  o_res = w_ai | w_bi;
            ALU_ADD: o_res = w_sum;
            default: o_res = i_less;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// serial_alu_ctrl
//   Bit-serial ALU sequencer: one WIDTH-bit op per handshake, evaluated one
//   bit per clock LSB->MSB through a single alu_bit_slice and a carry flop.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     flush                 sync abort back to IDLE, drops the op
//     in_valid / in_ready   request handshake (in_ready only in IDLE)
//     src_a, src_b          operands (latched on accept)
//     alu_ctrl              {a_invert, b_invert, op[1:0]}
//     out_valid / out_ready response handshake
//     result, zero, overflow response payload, held while out_valid
//     busy                  FSM not in IDLE
// ---------------------------------------------------------------------------
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam int             IW   = $clog2(WIDTH);
    localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    alu_ctrl_t        r_ctrl;
    logic             r_ovf;
    logic             r_set;

    logic w_last, w_res, w_set, w_ovf, w_cout;

    assign w_last = (r_idx == LAST);

    alu_bit_slice u_slice (
        .i_a        (r_a[r_idx]),
        .i_b        (r_b[r_idx]),
        .i_less     (1'b0),
        .i_a_invert (r_ctrl.a_inv),
        .i_b_invert (r_ctrl.b_inv),
        .i_cin      (r_carry),
        .i_op       (r_ctrl.op),
        .o_res      (w_res),
        .o_set      (w_set),
        .o_ovf      (w_ovf),
        .o_cout     (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_set    <= 1'b0;
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= src_a;
                        r_b      <= src_b;
                        r_ctrl   <= alu_ctrl_t'(alu_ctrl);
                        // b_invert doubles as the +1 of two's-complement subtract
                        r_carry  <= alu_ctrl[CTRL_BINV];
                        r_idx    <= '0;
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= w_res;
                    if (w_last) begin
                        // MSB carry-out is dropped; only set/overflow survive
                        r_set   <= w_set;
                        r_ovf   <= w_ovf;
                        r_state <= (r_ctrl.op == ALU_SLT) ? S_FIXUP : S_DONE;
                    end else begin
                        r_carry <= w_cout;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_result[0] <= r_set;
                    r_state     <= S_DONE;
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign zero      = ~|r_result;

endmodule
